// File: rtl/bus_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg: shared bus definitions for the switch and its graphics targets.
//   cmd_t             bus command encoding carried on cmdin/cmdout
//   len_t             beats-minus-one length field
//   RESP_TAR_DEFAULT  response target id used for read responses
//   GFX_Dn_BASE       base addresses of the four graphics device windows
//   ERR_RESP_DATA     data word returned with an error response
// -----------------------------------------------------------------------------
package bus_pkg;

    typedef enum logic [2:0] {
        CMD_IDLE   = 3'd0,
        CMD_READ   = 3'd1,
        CMD_WRITE  = 3'd2,
        CMD_RDRESP = 3'd3,
        CMD_ERR    = 3'd4
    } cmd_t;

    typedef logic [1:0] len_t;

    localparam logic [3:0]  RESP_TAR_DEFAULT = 4'hF;

    localparam logic [31:0] GFX_D0_BASE = 32'hF000_0000;
    localparam logic [31:0] GFX_D1_BASE = 32'hF000_0100;
    localparam logic [31:0] GFX_D2_BASE = 32'hF000_0200;
    localparam logic [31:0] GFX_D3_BASE = 32'hF000_0300;

    localparam logic [31:0] ERR_RESP_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/gfx_regfile.sv
// -----------------------------------------------------------------------------
// gfx_regfile: NREGS x 32-bit register file for the graphics target.
//   clk, reset      bus clock, synchronous active-high reset
//   we_i            write enable for this cycle
//   widx_i/wdata_i  write word index / write data
//   sticky_set_i    (GFX_TGT_ERR_RESP_EN only) set the out-of-range flag,
//                   bit 31 of the last register
//   ridx_i/rdata_o  combinational read port
//   regs_o          flattened register contents for the display engine
//   strobe_o        one-cycle pulse per register, aligned with the cycle in
//                   which the new value is first visible on regs_o
// Optional macro: GFX_TGT_ERR_RESP_EN (bit 31 of the last register becomes a
// sticky error flag that any write to that register clears).
// -----------------------------------------------------------------------------
module gfx_regfile #(
    parameter int NREGS = 16,
    parameter int IW    = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   we_i,
    input  logic [IW-1:0]          widx_i,
    input  logic [31:0]            wdata_i,
`ifdef GFX_TGT_ERR_RESP_EN
    input  logic                   sticky_set_i,
`endif
    input  logic [IW-1:0]          ridx_i,
    output logic [31:0]            rdata_o,
    output logic [32*NREGS-1:0]    regs_o,
    output logic [NREGS-1:0]       strobe_o
);

    logic [NREGS-1:0][31:0] regs_q;
    logic [NREGS-1:0]       strobe_q;

    // Register storage and write strobes; reset clears every word.
    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q   <= '0;
            strobe_q <= '0;
        end else begin
            strobe_q <= '0;
            if (we_i) begin
                regs_q[widx_i]   <= wdata_i;
                strobe_q[widx_i] <= 1'b1;
`ifdef GFX_TGT_ERR_RESP_EN
                // The flag bit is not data: writing the register clears it.
                if (widx_i == IW'(NREGS - 1)) begin
                    regs_q[widx_i][31] <= 1'b0;
                end
`endif
            end
`ifdef GFX_TGT_ERR_RESP_EN
            if (sticky_set_i) begin
                regs_q[NREGS-1][31] <= 1'b1;
            end
`endif
        end
    end

    assign rdata_o  = regs_q[ridx_i];
    assign regs_o   = regs_q;
    assign strobe_o = strobe_q;

endmodule

// File: rtl/gfx_target_if.sv
// -----------------------------------------------------------------------------
// gfx_target_if: bus-target front end for one graphics device.
//   clk, reset        bus clock, synchronous active-high reset
//   selin/cmdin       request select and command (first beat carries command)
//   addrdatain/lenin  beat 0 address, later beats write data; beats minus one
//   ackin             switch accepts the pending response (one-cycle pulse)
//   reqout/reqtar     response request and target id
//   addrdataout       response beat data
//   lenout/cmdout     response length and command
//   reg_q             flattened register file for the display engine
//   wr_strobe         one-cycle pulse per register written
// Optional macro: GFX_TGT_ERR_RESP_EN (out-of-range accesses get an error
// response / sticky flag instead of aliasing into the register file).
// -----------------------------------------------------------------------------
module gfx_target_if import bus_pkg::*; #(
    parameter logic [31:0] BASE_ADDR = GFX_D0_BASE,
    parameter int          NREGS     = 16,
    parameter logic [3:0]  RESP_TAR  = RESP_TAR_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   selin,
    input  logic [2:0]             cmdin,
    input  logic [31:0]            addrdatain,
    input  logic [1:0]             lenin,
    input  logic                   ackin,
    output logic                   reqout,
    output logic [3:0]             reqtar,
    output logic [31:0]            addrdataout,
    output logic [1:0]             lenout,
    output logic [2:0]             cmdout,
    output logic [32*NREGS-1:0]    reg_q,
    output logic [NREGS-1:0]       wr_strobe
);

    localparam int IW = $clog2(NREGS);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WDATA   = 3'd1,
        ST_RD_REQ  = 3'd2,
        ST_RD_DATA = 3'd3
`ifdef GFX_TGT_ERR_RESP_EN
        , ST_ERR   = 3'd4
`endif
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    len_t          len_q, len_d;
    len_t          cnt_q, cnt_d;
    logic [IW-1:0] cmd_idx_s;
    logic          rf_we_s;
    logic [31:0]   rf_rdata_s;
`ifdef GFX_TGT_ERR_RESP_EN
    logic          oor_q, oor_d;
    logic          cmd_oor_s;
    logic          sticky_set_s;
`endif

    // Word index is the offset into the device window; for an aligned base
    // the subtraction folds away.
    assign cmd_idx_s = addrdatain[IW+1:2] - BASE_ADDR[IW+1:2];
`ifdef GFX_TGT_ERR_RESP_EN
    assign cmd_oor_s = (addrdatain[7:IW+2] != BASE_ADDR[7:IW+2]);
`endif

    gfx_regfile #(.NREGS(NREGS), .IW(IW)) u_regfile (
        .clk          (clk),
        .reset        (reset),
        .we_i         (rf_we_s),
        .widx_i       (idx_q),
        .wdata_i      (addrdatain),
`ifdef GFX_TGT_ERR_RESP_EN
        .sticky_set_i (sticky_set_s),
`endif
        .ridx_i       (idx_q),
        .rdata_o      (rf_rdata_s),
        .regs_o       (reg_q),
        .strobe_o     (wr_strobe)
    );

    // State register and transaction context.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            len_q   <= 2'd0;
            cnt_q   <= 2'd0;
`ifdef GFX_TGT_ERR_RESP_EN
            oor_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
`ifdef GFX_TGT_ERR_RESP_EN
            oor_q   <= oor_d;
`endif
        end
    end

    // Next-state logic, beat counting and register-file write enable.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        rf_we_s = 1'b0;
`ifdef GFX_TGT_ERR_RESP_EN
        oor_d        = oor_q;
        sticky_set_s = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (selin && (cmdin == CMD_WRITE)) begin
                    idx_d   = cmd_idx_s;
                    len_d   = lenin;
                    cnt_d   = 2'd0;
                    state_d = ST_WDATA;
`ifdef GFX_TGT_ERR_RESP_EN
                    oor_d        = cmd_oor_s;
                    sticky_set_s = cmd_oor_s;
`endif
                end else if (selin && (cmdin == CMD_READ)) begin
                    idx_d   = cmd_idx_s;
                    len_d   = lenin;
                    cnt_d   = 2'd0;
`ifdef GFX_TGT_ERR_RESP_EN
                    state_d = cmd_oor_s ? ST_ERR : ST_RD_REQ;
`else
                    state_d = ST_RD_REQ;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WDATA: begin
                // selin low is a stall: neither write nor count.
                if (selin) begin
`ifdef GFX_TGT_ERR_RESP_EN
                    rf_we_s = ~oor_q;
`else
                    rf_we_s = 1'b1;
`endif
                    idx_d = idx_q + IW'(1);
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == len_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WDATA;
                    end
                end else begin
                    state_d = ST_WDATA;
                end
            end
            ST_RD_REQ: begin
                if (ackin) begin
                    if (len_q == 2'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        cnt_d   = 2'd1;
                        state_d = ST_RD_DATA;
                    end
                end else begin
                    state_d = ST_RD_REQ;
                end
            end
            ST_RD_DATA: begin
                if (cnt_q == len_q) begin
                    state_d = ST_IDLE;
                end else begin
                    idx_d   = idx_q + IW'(1);
                    cnt_d   = cnt_q + 2'd1;
                    state_d = ST_RD_DATA;
                end
            end
`ifdef GFX_TGT_ERR_RESP_EN
            ST_ERR: begin
                if (ackin) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ERR;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Response outputs decoded from the current state.
    always_comb begin
        reqout      = 1'b0;
        reqtar      = 4'h0;
        addrdataout = 32'h0000_0000;
        lenout      = 2'd0;
        cmdout      = CMD_IDLE;
        case (state_q)
            ST_RD_REQ: begin
                reqout      = 1'b1;
                reqtar      = RESP_TAR;
                lenout      = len_q;
                cmdout      = CMD_RDRESP;
                addrdataout = rf_rdata_s;
            end
            ST_RD_DATA: begin
                reqtar      = RESP_TAR;
                lenout      = len_q;
                cmdout      = CMD_RDRESP;
                addrdataout = rf_rdata_s;
            end
`ifdef GFX_TGT_ERR_RESP_EN
            ST_ERR: begin
                reqout      = 1'b1;
                reqtar      = RESP_TAR;
                lenout      = 2'd0;
                cmdout      = CMD_ERR;
                addrdataout = ERR_RESP_DATA;
            end
`endif
            default: begin
                reqout = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/gfx_target_if.md
Name: gfx_target_if

Overview:
- Bus-target front end for one graphics device (D0–D3). Sits directly downstream of the bus switch and consumes its per-device request outputs (selin/cmdin/addrdatain/lenin).
- Holds a small register file that the display engine reads.
- Decodes single- and multi-beat writes and reads.
- Returns read data to the switch as a new transaction: reqout is asserted with reqtar = RESP_TAR and the block waits for ackin.

Parameters:
BASE_ADDR, 32'hF000_0000, device base address; decode window is BASE_ADDR + 0x00..0xFF
NREGS, 16, number of 32-bit registers; word index is addr[5:2]
RESP_TAR, 4'hF, reqtar value driven on every response

Ports:
clk  in  1  bus clock
reset  in  1  synchronous, active-high
selin  in  1  switch selects this target; high for every request beat
cmdin  in  3  command on the first selin beat (bus_pkg::cmd_t)
addrdatain  in  32  beat 0 is the address; later beats are write data
lenin  in  2  beats minus one (0..3 gives 1..4 data words)
ackin  in  1  switch accepts the response; one-cycle pulse
reqout  out  1  response request to the switch
reqtar  out  4  response target
addrdataout  out  32  response beat data
lenout  out  2  response length, equal to the request lenin
cmdout  out  3  CMD_RDRESP while reqout or streaming, otherwise CMD_IDLE
reg_q  out  32*NREGS  flattened register file for the display engine
wr_strobe  out  NREGS  one-cycle pulse per register written

Behaviour:
- Reset: this is a synchronous reset and it overrides everything, mid-transaction included.
  - All outputs go to 0, cmdout goes to CMD_IDLE, registers go to 0, FSM goes to IDLE.
  - An in-flight burst is dropped.
- FSM states: IDLE, WDATA, RD_REQ, RD_DATA, plus ERR when the optional feature is enabled.
- IDLE:
  - On selin=1 and cmdin=CMD_WRITE: latch the word index and len, clear the beat counter, go to WDATA.
  - On selin=1 and cmdin=CMD_READ: latch the index and len, go to RD_REQ.
  - Any other cmdin with selin=1 is ignored.
- WDATA:
  - On each selin=1 cycle: write addrdatain to reg[idx], pulse wr_strobe[idx], then idx increments and wraps modulo NREGS.
  - When the counter reaches len, return to IDLE.
  - A selin=0 cycle is a stall: no write and no count.
- RD_REQ:
  - Drive reqout=1, reqtar=RESP_TAR, lenout=len, cmdout=CMD_RDRESP, and addrdataout=reg[idx] as beat 0.
  - Hold these until the cycle in which ackin=1.
  - On that cycle, go to RD_DATA with beat 1 (or to IDLE if len=0).
  - reqout drops the cycle after ackin.
- RD_DATA:
  - Drive one beat per cycle from reg[idx+k] with cmdout=CMD_RDRESP and reqout=0.
  - After beat len, drive cmdout=CMD_IDLE and go to IDLE.
- Latency:
  - Write: data is visible on reg_q the cycle after its beat.
  - Read: reqout rises one cycle after the command beat.
- Simultaneous events:
  - A write to reg[i] in the same cycle as a read beat of reg[i] returns the old value. No write can occur while reading, because the block is single-threaded.
  - selin=1 outside IDLE/WDATA is ignored; the switch serializes requests.
- Address bits:
  - Bits above [7:0] are not re-checked; decode is the switch's job.
  - addr[1:0] is ignored.
  - Index bits [7:6] nonzero is an out-of-range access. It aliases into the register file unless the optional feature is enabled.

Optional Feature:
- Macro: GFX_TGT_ERR_RESP_EN.
- When defined, out-of-range reads and writes change behaviour:
  - A read enters ERR: one response with reqout/ackin handshake, cmdout=CMD_ERR, lenout=0, addrdataout=32'hDEAD_BEEF.
  - A write drains its beats without writing and sets sticky bit reg[NREGS-1][31], which is cleared by a write to that register.
- When not defined: the address aliases modulo NREGS, there is no ERR state, and CMD_ERR is never driven.

Decomposition:
- bus_pkg holds:
  - cmd_t enum: CMD_IDLE=0, CMD_READ=1, CMD_WRITE=2, CMD_RDRESP=3, CMD_ERR=4.
  - len_t.
  - RESP_TAR_DEFAULT.
  - Device base constants 0xF000_0000/0100/0200/0300.
- One sub-module, gfx_regfile:
  - NREGS x 32 storage.
  - Synchronous write port with strobe output.
  - Combinational read port.

Test Plan:
- Reset with a write in progress: the burst is aborted, all reg_q=0, reqout=0, cmdout=CMD_IDLE.
- Single write:
  - Stimulus: selin/CMD_WRITE/addr 0xF000_0008/len 0, then data 0x1234_5678.
  - Expected: reg[2]=0x1234_5678 the next cycle; wr_strobe=0x0004 for one cycle.
- Burst write with wrap and stall:
  - Stimulus: addr index 14, len 3, data A,B,(stall),C,D.
  - Expected: reg14=A, reg15=B, reg0=C, reg1=D; no write on the stall cycle.
- Read, len 1, with ackin delayed 3 cycles:
  - reqout is held with reqtar=0xF, lenout=1, addrdataout=reg[idx].
  - After ackin: beat reg[idx+1], then CMD_IDLE and return to IDLE.
- Back-to-back: a write completes, then a read command on the next cycle. The read returns the newly written value.
- With GFX_TGT_ERR_RESP_EN:
  - Read of addr 0xF000_00C0 gives CMD_ERR and 0xDEAD_BEEF.
  - Write to the same address leaves the register file unchanged and sets reg15[31].
